// File: rtl/mat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mat_pkg : op codes, FSM state encoding and dimension-width helper          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mat_pkg;

    localparam logic [2:0] OP_TRANSPOSE = 3'b000;
    localparam logic [2:0] OP_ADD       = 3'b001;
    localparam logic [2:0] OP_SCALAR    = 3'b010;
    localparam logic [2:0] OP_MULT      = 3'b011;
    localparam logic [2:0] OP_CONV      = 3'b100;
    localparam logic [2:0] OP_SUB       = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_OUTPUT  = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_e;

    function automatic int dim_w(input int max_dim);
        return $clog2(max_dim + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mat_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mat_mac : signed multiply-accumulate with per-element clear                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mat_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W+5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic signed [ACC_W-1:0]  add_i,
    output logic signed [ACC_W-1:0]  sum_o
);

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    base;

    assign prod     = a_i * b_i;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    // clear_i restarts the sum on the first term of an element
    assign base     = clear_i ? '0 : acc_q;
    assign sum_o    = base + prod_ext + add_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= sum_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mat_ops_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mat_ops_gen : streaming matrix ops (transpose/add/sub/scale/mult/conv)     |
// | Optional macro MAT_OPS_SATURATE_EN clamps results instead of wrapping.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mat_ops_gen
    import mat_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int ACC_W   = 2*DATA_W+5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_op,
    input  logic [2:0]                          op_sel,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0]   matrix_a,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0]   matrix_b,
    input  logic [dim_w(MAX_DIM)-1:0]           dim_a_m,
    input  logic [dim_w(MAX_DIM)-1:0]           dim_a_n,
    input  logic [dim_w(MAX_DIM)-1:0]           dim_b_m,
    input  logic [dim_w(MAX_DIM)-1:0]           dim_b_n,
    input  logic [DATA_W-1:0]                   scalar_k,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_W-1:0]                   out_data,
    output logic [$clog2(MAX_DIM)-1:0]          out_row,
    output logic [$clog2(MAX_DIM)-1:0]          out_col,
    output logic                                out_last,
    output logic [dim_w(MAX_DIM)-1:0]           result_m,
    output logic [dim_w(MAX_DIM)-1:0]           result_n,
    output logic                                busy_flag,
    output logic                                op_done,
    output logic                                error_flag
);

    localparam int DW = dim_w(MAX_DIM);
    localparam int OW = $clog2(MAX_DIM);
    localparam int NE = MAX_DIM * MAX_DIM;
    localparam int IW = $clog2(NE);

    state_e                   state_q;
    logic [2:0]               op_q;
    logic [DW-1:0]            an_q, bm_q, bn_q;
    logic [DATA_W-1:0]        k_q;
    logic signed [DATA_W-1:0] mem_a_q [NE];
    logic signed [DATA_W-1:0] mem_b_q [NE];
    logic [OW-1:0]            row_q, col_q, ti_q, tj_q;

    logic signed [DATA_W-1:0] mac_a, mac_b;
    logic signed [ACC_W-1:0]  mac_add, mac_sum;
    logic [DW-1:0]            res_m_d, res_n_d;
    logic                     cmd_err, term_last, elem_last;

    function automatic logic [IW-1:0] idx(input int r, input int c);
        return IW'(r * MAX_DIM + c);
    endfunction

    function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic dim_bad(input logic [DW-1:0] d);
        return (d == '0) || (d > DW'(MAX_DIM));
    endfunction

    function automatic logic [DATA_W-1:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef MAT_OPS_SATURATE_EN
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = sext({1'b0, {(DATA_W-1){1'b1}}});
        lo = sext({1'b1, {(DATA_W-1){1'b0}}});
        if (v > hi) return hi[DATA_W-1:0];
        if (v < lo) return lo[DATA_W-1:0];
        return v[DATA_W-1:0];
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    assign cmd_err = (op_sel > OP_SUB)
                  || dim_bad(dim_a_m) || dim_bad(dim_a_n)
                  || dim_bad(dim_b_m) || dim_bad(dim_b_n)
                  || (((op_sel == OP_ADD) || (op_sel == OP_SUB))
                      && ((dim_a_m != dim_b_m) || (dim_a_n != dim_b_n)))
                  || ((op_sel == OP_MULT) && (dim_a_n != dim_b_m))
                  || ((op_sel == OP_CONV) && ((dim_b_m > dim_a_m) || (dim_b_n > dim_a_n)));

    always_comb begin
        res_m_d = dim_a_m;
        res_n_d = dim_a_n;
        case (op_sel)
            OP_TRANSPOSE: begin
                res_m_d = dim_a_n;
                res_n_d = dim_a_m;
            end
            OP_MULT: res_n_d = dim_b_n;
            OP_CONV: begin
                res_m_d = dim_a_m - dim_b_m + DW'(1);
                res_n_d = dim_a_n - dim_b_n + DW'(1);
            end
            default: ;
        endcase
    end

    // Operand routing: single-term ops use b=1 and carry B through the addend
    always_comb begin
        mac_a   = mem_a_q[idx(int'(row_q), int'(col_q))];
        mac_b   = DATA_W'(1);
        mac_add = '0;
        case (op_q)
            OP_TRANSPOSE: mac_a = mem_a_q[idx(int'(col_q), int'(row_q))];
            OP_ADD:       mac_add = sext(mem_b_q[idx(int'(row_q), int'(col_q))]);
            OP_SUB:       mac_add = -sext(mem_b_q[idx(int'(row_q), int'(col_q))]);
            OP_SCALAR:    mac_b = k_q;
            OP_MULT: begin
                mac_a = mem_a_q[idx(int'(row_q), int'(ti_q))];
                mac_b = mem_b_q[idx(int'(ti_q), int'(col_q))];
            end
            OP_CONV: begin
                mac_a = mem_a_q[idx(int'(row_q) + int'(ti_q), int'(col_q) + int'(tj_q))];
                mac_b = mem_b_q[idx(int'(ti_q), int'(tj_q))];
            end
            default: ;
        endcase
    end

    assign term_last = (op_q == OP_MULT) ? (DW'(ti_q) == an_q - DW'(1)) :
                       (op_q == OP_CONV) ? ((DW'(ti_q) == bm_q - DW'(1)) &&
                                            (DW'(tj_q) == bn_q - DW'(1))) : 1'b1;
    assign elem_last = (DW'(row_q) == result_m - DW'(1)) && (DW'(col_q) == result_n - DW'(1));

    mat_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clear_i ((ti_q == '0) && (tj_q == '0)),
        .en_i    (state_q == ST_COMPUTE),
        .a_i     (mac_a),
        .b_i     (mac_b),
        .add_i   (mac_add),
        .sum_o   (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD) begin
            for (int i = 0; i < NE; i++) begin
                mem_a_q[i] <= matrix_a[i*DATA_W +: DATA_W];
                mem_b_q[i] <= matrix_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_TRANSPOSE;
            an_q       <= '0;
            bm_q       <= '0;
            bn_q       <= '0;
            k_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            ti_q       <= '0;
            tj_q       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
            result_m   <= '0;
            result_n   <= '0;
            busy_flag  <= 1'b0;
            op_done    <= 1'b0;
            error_flag <= 1'b0;
        end else begin
            op_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_op) begin
                        if (cmd_err) begin
                            error_flag <= 1'b1;
                            state_q    <= ST_ERROR;
                        end else begin
                            op_q      <= op_sel;
                            an_q      <= dim_a_n;
                            bm_q      <= dim_b_m;
                            bn_q      <= dim_b_n;
                            k_q       <= scalar_k;
                            result_m  <= res_m_d;
                            result_n  <= res_n_d;
                            busy_flag <= 1'b1;
                            state_q   <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    row_q   <= '0;
                    col_q   <= '0;
                    ti_q    <= '0;
                    tj_q    <= '0;
                    state_q <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    if (term_last) begin
                        ti_q      <= '0;
                        tj_q      <= '0;
                        out_data  <= reduce(mac_sum);
                        out_row   <= row_q;
                        out_col   <= col_q;
                        out_last  <= elem_last;
                        out_valid <= 1'b1;
                        state_q   <= ST_OUTPUT;
                    end else if ((op_q == OP_CONV) && (DW'(tj_q) == bn_q - DW'(1))) begin
                        tj_q <= '0;
                        ti_q <= ti_q + OW'(1);
                    end else if (op_q == OP_CONV) begin
                        tj_q <= tj_q + OW'(1);
                    end else begin
                        ti_q <= ti_q + OW'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (elem_last) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_COMPUTE;
                            if (DW'(col_q) == result_n - DW'(1)) begin
                                col_q <= '0;
                                row_q <= row_q + OW'(1);
                            end else begin
                                col_q <= col_q + OW'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    op_done   <= 1'b1;
                    busy_flag <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                ST_ERROR: begin
                    if (start_op) begin
                        error_flag <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mat_ops_gen.md
MAT_OPS_GEN -- requirements
Module: mat_ops_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed element width.
REQ-002 SHALL have parameter MAX_DIM, default 5: maximum rows or columns of any matrix.
REQ-003 SHALL have parameter ACC_W, default 2*DATA_W+5: signed accumulator width.
REQ-004 SHALL provide ports: clk in 1, the single clock; rst in 1, a synchronous active-high reset.
REQ-005 SHALL provide ports: start_op in 1, command strobe; op_sel in 3, operation code.
REQ-006 SHALL provide ports: matrix_a in MAX_DIM*MAX_DIM*DATA_W, matrix_b in MAX_DIM*MAX_DIM*DATA_W; both row-major with stride MAX_DIM, element 0 in the LSBs.
REQ-007 SHALL provide ports: dim_a_m, dim_a_n, dim_b_m, dim_b_n in $clog2(MAX_DIM+1) each; scalar_k in DATA_W, signed.
REQ-008 SHALL provide ports: out_valid out 1; out_ready in 1; out_data out DATA_W; out_row and out_col out $clog2(MAX_DIM) each; out_last out 1.
REQ-009 SHALL provide ports: result_m and result_n out $clog2(MAX_DIM+1) each; busy_flag, op_done, error_flag out 1 each.

Function
REQ-010 SHALL use these op codes: 000 transpose, 001 add, 010 scalar multiply, 011 matrix multiply, 100 valid convolution (B is the kernel), 101 subtract (A-B); 110 and 111 are illegal.
REQ-011 SHALL implement states IDLE, LOAD, COMPUTE, OUTPUT, DONE, ERROR.
REQ-012 IDLE + start_op SHALL raise an error for any of: illegal op; any dimension 0 or >MAX_DIM; add/sub with mismatched dims; multiply with dim_a_n!=dim_b_m; conv with kernel larger than A. It SHALL go to ERROR on the next cycle.
REQ-013 Otherwise, IDLE + start_op SHALL latch op_sel, dims and scalar_k, set result_m/result_n, set busy_flag=1, and go to LOAD.
REQ-014 LOAD SHALL copy matrix_a/matrix_b into internal storage in one cycle, zero the element counter, and go to COMPUTE; input changes after this SHALL be ignored.
REQ-015 COMPUTE SHALL process one MAC term per cycle. Terms per element: 1 for transpose/add/sub/scalar, dim_a_n for multiply, dim_b_m*dim_b_n for conv. The accumulator SHALL clear at each element start. After the last term it SHALL go to OUTPUT.
REQ-016 OUTPUT SHALL hold out_valid=1 and keep out_data/out_row/out_col/out_last stable until out_ready=1. The transfer completes on the clk edge where both are high.
REQ-017 Elements SHALL be emitted row-major. out_last=1 only on element result_m*result_n-1.
REQ-018 After a transfer, the block SHALL go to COMPUTE for the next element, or to DONE after the last. out_valid SHALL drop the cycle after the transfer.
REQ-019 DONE SHALL pulse op_done=1 for exactly one cycle, clear busy_flag, and return to IDLE.
REQ-020 ERROR SHALL hold error_flag=1 with busy_flag=0. start_op SHALL return it to IDLE without accepting that command; error_flag SHALL clear on leaving ERROR.
REQ-021 start_op SHALL be ignored while busy_flag=1.
REQ-022 All arithmetic SHALL be signed in ACC_W bits. Output reduction to DATA_W SHALL follow REQ-026.
REQ-023 A 1x1 matrix SHALL produce one element with out_last=1. Latency from start_op to the first out_valid SHALL be 2+terms cycles.

Reset
REQ-024 rst SHALL force IDLE and drive all outputs to 0: out_valid, out_data, out_row, out_col, out_last, result_m, result_n, busy_flag, op_done, error_flag.
REQ-025 rst mid-operation SHALL abort the operation; no further elements or op_done SHALL follow.

Configuration
REQ-026 Macro MAT_OPS_SATURATE_EN defined: results above 2^(DATA_W-1)-1 or below -2^(DATA_W-1) SHALL clamp to those limits. Undefined: out_data SHALL be the low DATA_W bits, two's-complement wrap.

Structure
REQ-027 Op codes, the state enum and a dimension-width function SHALL live in shared package mat_pkg.
REQ-028 The signed multiply-accumulate (clear, enable, ACC_W accumulator) SHALL be sub-module mat_mac.

Verification
REQ-029 Multiply of 2x3 A=[1 2 3;4 5 6] by 3x2 B=[1 0;0 1;1 1] -> stream 4,5,10,11; out_last on 11; result 2x2; op_done once.
REQ-030 Conv of 3x3 A=1..9 with 2x2 B=[1 0;0 1] -> 6,8,12,14; result 2x2.
REQ-031 Add with A 2x2 and B 2x3 -> error_flag=1 one cycle after start_op, no out_valid; a later start_op returns to IDLE.
REQ-032 Scalar 3*[100] -> SATURATE_EN 127; without it 44. Sub [-100]-[100] -> -128 with SATURATE_EN, 56 without.
REQ-033 Transpose 2x3 A=[1 2 3;4 5 6] with out_ready low for 3 cycles per element -> data held stable; stream 1,4,2,5,3,6; result 3x2.
REQ-034 rst asserted after 2 of 4 elements of a 2x2 add -> all outputs 0 next cycle; no further out_valid or op_done.
